// File: rtl/flow_seq_pkg.sv
// Shared types and helpers for the flow-counter sequence-window controller.
package flow_seq_pkg;

  localparam int unsigned SeqWDefault = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StRecover = 2'd2
  } seq_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] mask);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, mask[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/seq_advance8.sv
// Sequence pointer advance: val + popcount(mask), or load_val when load is set.
module seq_advance8
  import flow_seq_pkg::*;
#(
  parameter int unsigned W = SeqWDefault
) (
  input  logic [W-1:0] val_i,
  input  logic [7:0]   mask_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] res_o
);

  // Pure combinational advance; the caller registers the result.
  always_comb begin
    res_o = load_i ? load_val_i : val_i + W'(popcount8(mask_i));
  end

endmodule

// File: rtl/flow_seq_ctrl.sv
// Sequence-window controller: owns the allocation and oldest-uncommitted pointers.
module flow_seq_ctrl
  import flow_seq_pkg::*;
#(
  parameter int unsigned SEQ_W       = SeqWDefault,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEQ_W-1:0] start_seq,
  input  logic             alloc_valid,
  input  logic [7:0]       alloc_mask,
  output logic             alloc_ready,
  output logic [SEQ_W-1:0] alloc_base,
  output logic [3:0]       alloc_count,
  input  logic             commit_valid,
  input  logic [7:0]       commit_mask,
  input  logic             kill,
  input  logic [SEQ_W-1:0] kill_seq,
  output logic [SEQ_W-1:0] next_seq,
  output logic [SEQ_W-1:0] commit_seq,
  output logic [SEQ_W-1:0] occupancy,
  output logic [1:0]       state,
  output logic             err
);

  localparam int unsigned CntW = $clog2(RECOVER_CYC + 1);

  seq_state_e       state_q, state_d;
  logic [SEQ_W-1:0] next_seq_q, next_seq_d;
  logic [SEQ_W-1:0] commit_seq_q, commit_seq_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  rcnt_q, rcnt_d;

  logic [SEQ_W-1:0] occ, occ_post, kill_off, next_load_val;
  logic             start_load, commit_act, kill_act, commit_over, kill_legal, room, fire;
  logic [3:0]       commit_cnt;

  // Window bookkeeping, ready decision and kill range check.
  always_comb begin
    occ         = next_seq_q - commit_seq_q;
    start_load  = (state_q == StIdle) && start;
    commit_act  = (state_q != StIdle) && commit_valid;
    kill_act    = (state_q != StIdle) && kill;
    commit_cnt  = popcount8(commit_mask);
    // Over-commit clamps to the allocation pointer.
    commit_over = commit_act && (SEQ_W'(commit_cnt) > occ);
    // Room check ignores the mask so ready never depends on valid.
    room        = ({1'b0, occ} + (SEQ_W + 1)'(8)) <= (SEQ_W + 1)'(WINDOW);
    alloc_ready = (state_q == StRun) && !kill && room;
    fire        = alloc_valid && alloc_ready;
    // Kill range is judged against the post-commit window.
    occ_post    = next_seq_q - commit_seq_d;
    kill_off    = kill_seq - commit_seq_d;
    kill_legal  = kill_off <= occ_post;
    next_load_val = start_load ? start_seq : (kill_legal ? kill_seq : commit_seq_d);
  end

  seq_advance8 #(
    .W (SEQ_W)
  ) u_commit_adv (
    .val_i      (commit_seq_q),
    .mask_i     (commit_act ? commit_mask : 8'h00),
    .load_i     (start_load || commit_over),
    .load_val_i (start_load ? start_seq : next_seq_q),
    .res_o      (commit_seq_d)
  );

  seq_advance8 #(
    .W (SEQ_W)
  ) u_next_adv (
    .val_i      (next_seq_q),
    .mask_i     (fire ? alloc_mask : 8'h00),
    .load_i     (start_load || kill_act),
    .load_val_i (next_load_val),
    .res_o      (next_seq_d)
  );

  // FSM next state, recovery countdown and sticky error.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    err_d   = err_q || commit_over || (kill_act && !kill_legal);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (kill) begin
          state_d = StRecover;
          rcnt_d  = CntW'(RECOVER_CYC);
        end
      end
      StRecover: begin
        if (kill) begin
          rcnt_d = CntW'(RECOVER_CYC);
        end else begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q <= CntW'(1)) state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All controller state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      next_seq_q   <= '0;
      commit_seq_q <= '0;
      err_q        <= 1'b0;
      rcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      next_seq_q   <= next_seq_d;
      commit_seq_q <= commit_seq_d;
      err_q        <= err_d;
      rcnt_q       <= rcnt_d;
    end
  end

  // Outputs are straight views of the registers plus the combinational alloc info.
  always_comb begin
    alloc_base  = next_seq_q;
    alloc_count = popcount8(alloc_mask);
    next_seq    = next_seq_q;
    commit_seq  = commit_seq_q;
    occupancy   = occ;
    state       = state_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_flow_seq_ctrl.sv
// Self-checking bench for flow_seq_ctrl: directed scenarios plus randomized traffic.
module tb_flow_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, alloc_valid, commit_valid, kill;
  logic [7:0] start_seq, alloc_mask, commit_mask, kill_seq;
  logic       alloc_ready, err;
  logic [7:0] alloc_base, next_seq, commit_seq, occupancy;
  logic [3:0] alloc_count;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pointers, state, sticky error, recovery cycles left.
  logic [7:0] m_next, m_commit;
  logic [1:0] m_state;
  logic       m_err;
  int         m_cnt;

  always #5 clk = ~clk;

  flow_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_seq    (start_seq),
    .alloc_valid  (alloc_valid),
    .alloc_mask   (alloc_mask),
    .alloc_ready  (alloc_ready),
    .alloc_base   (alloc_base),
    .alloc_count  (alloc_count),
    .commit_valid (commit_valid),
    .commit_mask  (commit_mask),
    .kill         (kill),
    .kill_seq     (kill_seq),
    .next_seq     (next_seq),
    .commit_seq   (commit_seq),
    .occupancy    (occupancy),
    .state        (state),
    .err          (err)
  );

  function automatic logic m_ready();
    logic [7:0] o;
    o = m_next - m_commit;
    return (m_state == 2'd1) && !kill && (int'(o) + 8 <= 64);
  endfunction

  task automatic model_reset();
    m_next = 8'h00; m_commit = 8'h00; m_state = 2'd0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Apply one clock of the window rules to the model using the current inputs.
  task automatic model_step();
    logic [7:0] o, c, off, o2;
    logic       f;
    o = m_next - m_commit;
    f = m_ready() && alloc_valid;
    if (m_state == 2'd0) begin
      if (start) begin
        m_next = start_seq; m_commit = start_seq; m_state = 2'd1;
      end
    end else begin
      if (commit_valid) begin
        c = 8'($countones(commit_mask));
        if (c > o) begin m_commit = m_commit + o; m_err = 1'b1; end
        else m_commit = m_commit + c;
      end
      if (kill) begin
        off = kill_seq - m_commit;
        o2  = m_next - m_commit;
        if (off <= o2) m_next = kill_seq;
        else begin m_next = m_commit; m_err = 1'b1; end
        m_state = 2'd2; m_cnt = 2;
      end else begin
        if (f) m_next = m_next + 8'($countones(alloc_mask));
        if (m_state == 2'd2) begin
          m_cnt--;
          if (m_cnt == 0) m_state = 2'd1;
        end
      end
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] ss, input logic av, input logic [7:0] am,
                       input logic cv, input logic [7:0] cm, input logic k, input logic [7:0] ks);
    @(negedge clk);
    start = st; start_seq = ss; alloc_valid = av; alloc_mask = am;
    commit_valid = cv; commit_mask = cm; kill = k; kill_seq = ks;
    #1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; start_seq = 0; alloc_valid = 0; alloc_mask = 0;
    commit_valid = 0; commit_mask = 0; kill = 0; kill_seq = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] s);
    drive(1'b1, s, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_total++; if (next_seq !== 8'h00) $display("FAIL reset_next: got %h want 00", next_seq); else n_pass++;
    n_total++; if (commit_seq !== 8'h00) $display("FAIL reset_commit: got %h want 00", commit_seq); else n_pass++;
    n_total++; if (occupancy !== 8'h00) $display("FAIL reset_occ: got %h want 00", occupancy); else n_pass++;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", alloc_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    // Commit and kill in IDLE must not move anything.
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h33);
    cyc();
    n_total++; if (state !== 2'd0 || next_seq !== 8'h00 || err !== 1'b0)
      $display("FAIL idle_ignore: got st=%0d next=%h err=%b want 0/00/0", state, next_seq, err);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    do_start(8'hFC);
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (alloc_ready !== 1'b1 || alloc_base !== 8'hFC || alloc_count !== 4'd8)
      $display("FAIL wrap_g1: got rdy=%b base=%h cnt=%0d want 1/fc/8", alloc_ready, alloc_base, alloc_count);
    else n_pass++;
    cyc();
    drive(1'b0, 8'h00, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (alloc_base !== 8'h04 || alloc_count !== 4'd4)
      $display("FAIL wrap_g2: got base=%h cnt=%0d want 04/4", alloc_base, alloc_count);
    else n_pass++;
    cyc();
    n_total++; if (next_seq !== 8'h08) $display("FAIL wrap_next: got %h want 08", next_seq); else n_pass++;
    n_total++; if (occupancy !== 8'd12) $display("FAIL wrap_occ: got %0d want 12", occupancy); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    do_start(8'h00);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (occupancy !== 8'd56 || alloc_ready !== 1'b1)
      $display("FAIL full_7: got occ=%0d rdy=%b want 56/1", occupancy, alloc_ready);
    else n_pass++;
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (occupancy !== 8'd64 || alloc_ready !== 1'b0)
      $display("FAIL full_8: got occ=%0d rdy=%b want 64/0", occupancy, alloc_ready);
    else n_pass++;
    cyc();
    n_total++; if (next_seq !== 8'h40) $display("FAIL full_nofire: got %h want 40", next_seq); else n_pass++;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (occupancy !== 8'd63 || alloc_ready !== 1'b0)
      $display("FAIL full_c1: got occ=%0d rdy=%b want 63/0", occupancy, alloc_ready);
    else n_pass++;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (occupancy !== 8'd55 || alloc_ready !== 1'b1)
      $display("FAIL full_c8: got occ=%0d rdy=%b want 55/1", occupancy, alloc_ready);
    else n_pass++;
  endtask

  // Leaves next_seq 0x20, commit_seq 0x10.
  task automatic setup_10_20();
    do_reset();
    do_start(8'h10);
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic test_kill();
    setup_10_20();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h18);
    cyc();
    n_total++; if (next_seq !== 8'h18 || occupancy !== 8'd8 || state !== 2'd2)
      $display("FAIL kill_apply: got next=%h occ=%0d st=%0d want 18/8/2", next_seq, occupancy, state);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
      n_total++; if (alloc_ready !== 1'b0 || state !== 2'd2)
        $display("FAIL kill_recover%0d: got rdy=%b st=%0d want 0/2", i, alloc_ready, state);
      else n_pass++;
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    n_total++; if (alloc_ready !== 1'b1 || state !== 2'd1 || next_seq !== 8'h18)
      $display("FAIL kill_resume: got rdy=%b st=%0d next=%h want 1/1/18", alloc_ready, state, next_seq);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    setup_10_20();
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h0F, 1'b1, 8'h14);
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL simul_ready: got %b want 0", alloc_ready); else n_pass++;
    cyc();
    n_total++; if (commit_seq !== 8'h14 || next_seq !== 8'h14 || occupancy !== 8'h00 || err !== 1'b0)
      $display("FAIL simul_result: got c=%h n=%h occ=%0d err=%b want 14/14/0/0",
               commit_seq, next_seq, occupancy, err);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    do_start(8'h00);
    drive(1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00);
    cyc();
    n_total++; if (commit_seq !== 8'h03 || err !== 1'b1)
      $display("FAIL err_overcommit: got c=%h err=%b want 03/1", commit_seq, err);
    else n_pass++;
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h40);
    cyc();
    n_total++; if (next_seq !== 8'h03 || err !== 1'b1 || state !== 2'd2)
      $display("FAIL err_badkill: got n=%h err=%b st=%0d want 03/1/2", next_seq, err, state);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    setup_10_20();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h90);
    cyc();
    #2;
    rst_n = 1'b0;
    alloc_valid = 1'b1;
    #1;
    n_total++; if (state !== 2'd0 || next_seq !== 8'h00 || commit_seq !== 8'h00 ||
                   alloc_ready !== 1'b0 || err !== 1'b0)
      $display("FAIL async_reset: got st=%0d n=%h c=%h rdy=%b err=%b want 0/00/00/0/0",
               state, next_seq, commit_seq, alloc_ready, err);
    else n_pass++;
    model_reset();
    alloc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int errs;
    logic [7:0] o, ks;
    errs = 0;
    do_reset();
    do_start(8'($urandom));
    for (int i = 0; i < 400; i++) begin
      o  = m_next - m_commit;
      ks = ($urandom_range(0, 1) == 1) ? 8'(m_commit + 8'($urandom_range(0, int'(o) + 2)))
                                        : 8'($urandom);
      drive(($urandom_range(0, 7) == 0), 8'($urandom),
            ($urandom_range(0, 1) == 1), 8'($urandom),
            ($urandom_range(0, 3) == 0), 8'($urandom) & 8'($urandom),
            ($urandom_range(0, 15) == 0), ks);
      if (alloc_ready !== m_ready() || alloc_base !== m_next ||
          alloc_count !== 4'($countones(alloc_mask))) errs++;
      cyc();
      if (next_seq !== m_next || commit_seq !== m_commit || occupancy !== 8'(m_next - m_commit) ||
          state !== m_state || err !== m_err) begin
        if (errs < 5)
          $display("FAIL rand_cycle%0d: got n=%h c=%h st=%0d err=%b want %h/%h/%0d/%b",
                   i, next_seq, commit_seq, state, err, m_next, m_commit, m_state, m_err);
        errs++;
      end
    end
    n_total++;
    if (errs != 0) $display("FAIL rand_total: got %0d mismatching cycles want 0", errs);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_wrap();
    test_full();
    test_kill();
    test_simultaneous();
    test_errors();
    test_async_reset();
    test_random();
    idle_cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
